// File: rtl/sr_bank_arbiter_if.sv
// sr_bank_arbiter_if
//   Bus between the requesters / status consumers and sr_bank_arbiter.
//   master : front-end side, drives requests and commands, observes bank state.
//   slave  : arbiter side, receives commands, drives grants, bank and error status.
// Signals:
//   req[NREQ]                request per requester, held until granted
//   cmd_s[NREQ], cmd_r[NREQ] set / reset bits of each requester's command
//   cmd_addr[NREQ*ADDR_W]    target bit; requester i at [i*ADDR_W +: ADDR_W]
//   clr_all                  synchronous clear of the whole bank
//   gnt[NREQ]                registered one-hot grant pulse
//   q[NBITS]                 bank contents
//   busy                     a latched command is being applied this cycle
//   err, err_src, err_count  invalid-command pulse, source, saturating count
interface sr_bank_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int NBITS  = 8,
    parameter int ADDR_W = 3,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        cmd_s;
    logic [NREQ-1:0]        cmd_r;
    logic [NREQ*ADDR_W-1:0] cmd_addr;
    logic                   clr_all;
    logic [NREQ-1:0]        gnt;
    logic [NBITS-1:0]       q;
    logic                   busy;
    logic                   err;
    logic [IDX_W-1:0]       err_src;
    logic [CNT_W-1:0]       err_count;

    modport master (
        output req, cmd_s, cmd_r, cmd_addr, clr_all,
        input  gnt, q, busy, err, err_src, err_count
    );

    modport slave (
        input  req, cmd_s, cmd_r, cmd_addr, clr_all,
        output gnt, q, busy, err, err_src, err_count
    );
endinterface

// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter
//   Shares one bank of NBITS set/reset storage bits between NREQ requesters.
//   A round-robin arbiter grants one command per cycle (stage 1: grant + latch),
//   and the latched command is applied to the bank on the following edge
//   (stage 2: apply). Invalid commands (S=R=1 or address >= NBITS) are consumed
//   without touching the bank, pulse err and bump a saturating counter.
// Ports:
//   clk      clock, all state on rising edge
//   reset_n  asynchronous active-low reset
//   bus      sr_bank_arbiter_if.slave (requests/commands in, grant/bank/status out)
module sr_bank_arbiter #(
    parameter int NREQ   = 4,
    parameter int NBITS  = 8,
    parameter int ADDR_W = 3,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    sr_bank_arbiter_if.slave  bus
);

    typedef enum logic {
        StIdle,
        StApply
    } state_t;

    localparam logic [ADDR_W:0] NBitsExt = (ADDR_W+1)'(NBITS);

    state_t              r_state;
    state_t              w_state_next;

    logic [NREQ-1:0]     r_gnt;
    logic [NREQ-1:0]     w_gnt_next;
    logic [NREQ-1:0]     w_elig;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_win;
    logic                w_found;
    logic                w_sel_s;
    logic                w_sel_r;
    logic [ADDR_W-1:0]   w_sel_addr;

    logic                r_lat_s;
    logic                r_lat_r;
    logic [ADDR_W-1:0]   r_lat_addr;
    logic [IDX_W-1:0]    r_lat_src;

    logic [NBITS-1:0]    r_q;
    logic [NBITS-1:0]    w_q_next;
    logic                w_invalid;
    logic                w_apply_err;
    logic                r_err;
    logic [IDX_W-1:0]    r_err_src;
    logic [CNT_W-1:0]    r_err_count;

    // A requester whose grant is still visible is masked, so it can drop req
    // after seeing gnt without being issued twice.
    assign w_elig = bus.req & ~r_gnt;

    // Round-robin search starting just after the last winner.
    always_comb begin
        int idx;
        idx        = 0;
        w_found    = 1'b0;
        w_win      = '0;
        w_gnt_next = '0;
        w_sel_s    = 1'b0;
        w_sel_r    = 1'b0;
        w_sel_addr = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && w_elig[idx]) begin
                w_found         = 1'b1;
                w_win           = IDX_W'(idx);
                w_gnt_next[idx] = 1'b1;
                w_sel_s         = bus.cmd_s[idx];
                w_sel_r         = bus.cmd_r[idx];
                w_sel_addr      = bus.cmd_addr[idx*ADDR_W +: ADDR_W];
            end
        end
    end

    // FSM: APPLY while a latched command is pending for the next edge.
    always_comb begin
        w_state_next = StIdle;
        if (w_found) begin
            w_state_next = StApply;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Apply stage.
    always_comb begin
        w_invalid   = (r_lat_s & r_lat_r) | ({1'b0, r_lat_addr} >= NBitsExt);
        w_apply_err = (r_state == StApply) & w_invalid;
        w_q_next    = r_q;
        if (r_state == StApply && !w_invalid) begin
            for (int i = 0; i < NBITS; i++) begin
                if (r_lat_addr == ADDR_W'(i)) begin
                    if (r_lat_s) begin
                        w_q_next[i] = 1'b1;
                    end else if (r_lat_r) begin
                        w_q_next[i] = 1'b0;
                    end
                end
            end
        end
        // Clear wins over whatever is applied on the same edge.
        if (bus.clr_all) begin
            w_q_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt       <= '0;
            r_ptr       <= IDX_W'(NREQ - 1);
            r_lat_s     <= 1'b0;
            r_lat_r     <= 1'b0;
            r_lat_addr  <= '0;
            r_lat_src   <= '0;
            r_q         <= '0;
            r_err       <= 1'b0;
            r_err_src   <= '0;
            r_err_count <= '0;
        end else begin
            r_gnt <= w_gnt_next;
            if (w_found) begin
                r_ptr      <= w_win;
                r_lat_s    <= w_sel_s;
                r_lat_r    <= w_sel_r;
                r_lat_addr <= w_sel_addr;
                r_lat_src  <= w_win;
            end
            r_q   <= w_q_next;
            r_err <= w_apply_err;
            if (w_apply_err) begin
                r_err_src <= r_lat_src;
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.q         = r_q;
    assign bus.busy      = (r_state == StApply);
    assign bus.err       = r_err;
    assign bus.err_src   = r_err_src;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Testbench for sr_bank_arbiter: an 8-bit bank instance and a 6-bit bank
// instance share the same stimulus; a behavioural model tracks both and is
// compared every negative clock edge, plus literal checks on directed cases.
module tb_sr_bank_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 3;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 8;

    logic clk;
    logic reset_n;

    sr_bank_arbiter_if #(.NREQ(NREQ), .NBITS(8), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                         .CNT_W(CNT_W)) bus ();
    sr_bank_arbiter_if #(.NREQ(NREQ), .NBITS(6), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                         .CNT_W(CNT_W)) bus6 ();

    assign bus6.req      = bus.req;
    assign bus6.cmd_s    = bus.cmd_s;
    assign bus6.cmd_r    = bus.cmd_r;
    assign bus6.cmd_addr = bus.cmd_addr;
    assign bus6.clr_all  = bus.clr_all;

    sr_bank_arbiter #(.NREQ(NREQ), .NBITS(8), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                      .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    sr_bank_arbiter #(.NREQ(NREQ), .NBITS(6), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                      .CNT_W(CNT_W)) dut6 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         nb [2] = '{8, 6};
    logic [3:0] m_gnt  = '0;
    int         m_ptr  = NREQ - 1;
    bit         p_valid = 0;
    bit         p_s = 0, p_r = 0;
    int         p_addr = 0, p_src = 0;
    logic [7:0] m_q   [2] = '{8'h00, 8'h00};
    bit         m_err [2] = '{0, 0};
    int         m_src [2] = '{0, 0};
    int         m_cnt [2] = '{0, 0};

    always @(posedge clk or negedge reset_n) begin
        int win;
        int idx;
        if (!reset_n) begin
            m_gnt   = '0;
            m_ptr   = NREQ - 1;
            p_valid = 0;
            for (int b = 0; b < 2; b++) begin
                m_q[b] = '0; m_err[b] = 0; m_src[b] = 0; m_cnt[b] = 0;
            end
        end else begin
            // command granted last edge lands now
            for (int b = 0; b < 2; b++) begin
                m_err[b] = 0;
                if (p_valid) begin
                    if ((p_s && p_r) || p_addr >= nb[b]) begin
                        m_err[b] = 1;
                        m_src[b] = p_src;
                        if (m_cnt[b] < 255) m_cnt[b]++;
                    end else if (p_s) begin
                        m_q[b][p_addr] = 1'b1;
                    end else if (p_r) begin
                        m_q[b][p_addr] = 1'b0;
                    end
                end
                if (bus.clr_all) m_q[b] = '0;
            end
            // pick next winner among requesters without a visible grant
            win = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (win < 0 && bus.req[idx] && !m_gnt[idx]) win = idx;
            end
            if (win >= 0) begin
                p_valid = 1;
                p_s     = bus.cmd_s[win];
                p_r     = bus.cmd_r[win];
                p_addr  = int'(bus.cmd_addr[win*ADDR_W +: ADDR_W]);
                p_src   = win;
                m_ptr   = win;
                m_gnt   = 4'(1 << win);
            end else begin
                p_valid = 0;
                m_gnt   = '0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("gnt",        32'(bus.gnt),        32'(m_gnt));
        chk("gnt6",       32'(bus6.gnt),       32'(m_gnt));
        chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
        chk("busy",       32'(bus.busy),       32'(p_valid));
        chk("q",          32'(bus.q),          32'(m_q[0]));
        chk("q6",         32'(bus6.q),         32'(m_q[1][5:0]));
        chk("err",        32'(bus.err),        32'(m_err[0]));
        chk("err6",       32'(bus6.err),       32'(m_err[1]));
        chk("err_src",    32'(bus.err_src),    32'(m_src[0]));
        chk("err_src6",   32'(bus6.err_src),   32'(m_src[1]));
        chk("err_count",  32'(bus.err_count),  32'(m_cnt[0]));
        chk("err_count6", 32'(bus6.err_count), 32'(m_cnt[1]));
    end

    // ---------------- directed stimulus ----------------
    // Raise req[i] with a command and drop it once its grant is visible.
    task automatic issue(input int i, input bit s, input bit r, input int a);
        bit got;
        got = 0;
        bus.cmd_s[i] = s;
        bus.cmd_r[i] = r;
        bus.cmd_addr[i*ADDR_W +: ADDR_W] = 3'(a);
        bus.req[i] = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            if (m_gnt[i]) got = 1;
        end
        bus.req[i] = 1'b0;
        chk("issue_granted", 32'(got), 32'd1);
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        bus.req      = '0;
        bus.cmd_s    = '0;
        bus.cmd_r    = '0;
        bus.cmd_addr = '0;
        bus.clr_all  = 1'b0;
        reset_n      = 1'b1;
        #2 reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_q",     32'(bus.q),         32'h0);
        chk("rst_gnt",   32'(bus.gnt),       32'h0);
        chk("rst_count", 32'(bus.err_count), 32'h0);

        // 1: single set of bit 3 from requester 0
        bus.cmd_s[0] = 1'b1;
        bus.cmd_addr[2:0] = 3'd3;
        bus.req[0] = 1'b1;
        @(posedge clk); #1;
        chk("t1_gnt",  32'(bus.gnt),  32'b0001);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_q0",   32'(bus.q),    32'h00);
        bus.req[0] = 1'b0;
        @(posedge clk); #1;
        chk("t1_q",    32'(bus.q),    32'h08);
        chk("t1_idle", 32'(bus.busy), 32'd0);
        chk("t1_err",  32'(bus.err),  32'd0);

        // 2: all four request together; pointer sits at 0 after test 1
        bus.cmd_s    = 4'b0111;
        bus.cmd_r    = 4'b1000;
        bus.cmd_addr = {3'd3, 3'd2, 3'd1, 3'd0};
        bus.req      = 4'hF;
        for (int g = 0; g < 5; g++) begin
            @(posedge clk); #1;
            chk("t2_rr_gnt", 32'(bus.gnt), 32'(rr_exp[g]));
        end
        bus.req = '0;
        drain();
        chk("t2_q", 32'(bus.q), 32'h07);

        // 3: S=R=1 from requester 2, then saturate the counter
        issue(2, 1, 1, 0);
        @(posedge clk); #1;
        chk("t3_err",     32'(bus.err),       32'd1);
        chk("t3_src",     32'(bus.err_src),   32'd2);
        chk("t3_count",   32'(bus.err_count), 32'd1);
        chk("t3_q",       32'(bus.q),         32'h07);
        for (int n = 1; n < 300; n++) issue(2, 1, 1, 0);
        drain();
        chk("t3_sat",     32'(bus.err_count), 32'd255);

        // 4: fill bank, then reset bit 0 on the same edge as clr_all
        for (int a = 0; a < 8; a++) issue(0, 1, 0, a);
        drain();
        chk("t4_full", 32'(bus.q), 32'hFF);
        bus.cmd_s[1] = 1'b0;
        bus.cmd_r[1] = 1'b1;
        bus.cmd_addr[5:3] = 3'd0;
        bus.req[1] = 1'b1;
        @(posedge clk); #1;
        chk("t4_gnt", 32'(bus.gnt), 32'b0010);
        bus.req[1]  = 1'b0;
        bus.clr_all = 1'b1;
        @(posedge clk); #1;
        bus.clr_all = 1'b0;
        chk("t4_clr", 32'(bus.q), 32'h00);
        issue(1, 0, 0, 0);
        @(posedge clk); #1;
        chk("t4_nop_q",   32'(bus.q),   32'h00);
        chk("t4_nop_err", 32'(bus.err), 32'd0);

        // 5: address 7 is out of range only for the 6-bit bank
        issue(3, 1, 0, 7);
        @(posedge clk); #1;
        chk("t5_err6", 32'(bus6.err),     32'd1);
        chk("t5_src6", 32'(bus6.err_src), 32'd3);
        chk("t5_q6",   32'(bus6.q),       32'h00);
        chk("t5_q8",   32'(bus.q),        32'h80);
        chk("t5_err8", 32'(bus.err),      32'd0);
        drain();

        // 6: reset between grant and apply of a set to bit 5
        issue(0, 1, 0, 5);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_q",    32'(bus.q),    32'h00);
        chk("t6_q6",   32'(bus6.q),   32'h00);
        chk("t6_gnt",  32'(bus.gnt),  32'h0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        bus.cmd_s    = 4'b0011;
        bus.cmd_r    = 4'b0000;
        bus.cmd_addr = {3'd0, 3'd0, 3'd2, 3'd1};
        bus.req      = 4'b0011;
        @(posedge clk); #1;
        chk("t6_first", 32'(bus.gnt), 32'b0001);
        bus.req[0] = 1'b0;
        @(posedge clk); #1;
        chk("t6_second", 32'(bus.gnt), 32'b0010);
        bus.req[1] = 1'b0;
        drain();
        chk("t6_final_q", 32'(bus.q), 32'h06);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
